ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem.sv | 134 +++++++++++++
 tb/tb_ex_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: branch target, ALU, dest-reg select, registered outputs.
// Latency 1 clk; stall holds all outputs, flush (priority) loads a bubble; async reset clears.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ctlwb_in,
    input  logic [2:0]  ctlm_in,
    input  logic        regdst,
    input  logic        alusrc,
    input  logic [1:0]  aluop,
    input  logic [31:0] npc,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] s_extend,
    input  logic [4:0]  instr_2016,
    input  logic [4:0]  instr_1511,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    output logic [1:0]  wb_ctlout,
    output logic [2:0]  m_ctlout,
    output logic [31:0] add_result,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] rdata2out,
    output logic [4:0]  muxout,
    output logic        valid_out,
    output logic        illegal
);

    logic [1:0]  wb_q, wb_d;
    logic [2:0]  m_q, m_d;
    logic [31:0] add_q, add_d;
    logic [31:0] alu_q, alu_d;
    logic        zero_q, zero_d;
    logic [31:0] rd2_q, rd2_d;
    logic [4:0]  mux_q, mux_d;
    logic        valid_q, valid_d;
    logic        illegal_q, illegal_d;

    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        bad_op;

    always_comb begin
        op_b    = alusrc ? s_extend : rdata2;
        alu_res = 32'd0;
        bad_op  = 1'b0;
        case (aluop)
            2'b00: alu_res = rdata1 + op_b;
            2'b01: alu_res = rdata1 - op_b;
            2'b10: begin
                case (s_extend[5:0])
                    6'b100000: alu_res = rdata1 + op_b;
                    6'b100010: alu_res = rdata1 - op_b;
                    6'b100100: alu_res = rdata1 & op_b;
                    6'b100101: alu_res = rdata1 | op_b;
                    6'b101010: alu_res = ($signed(rdata1) < $signed(op_b)) ? 32'd1 : 32'd0;
                    default:   bad_op  = 1'b1;
                endcase
            end
            default: bad_op = 1'b1;
        endcase
    end

    always_comb begin
        wb_d      = wb_q;
        m_d       = m_q;
        add_d     = add_q;
        alu_d     = alu_q;
        zero_d    = zero_q;
        rd2_d     = rd2_q;
        mux_d     = mux_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        if (flush) begin
            wb_d      = 2'b00;
            m_d       = 3'b000;
            add_d     = 32'd0;
            alu_d     = 32'd0;
            zero_d    = 1'b0;
            rd2_d     = 32'd0;
            mux_d     = 5'd0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            // Controls are gated by valid so a non-instruction can never write or branch.
            wb_d      = valid_in ? ctlwb_in : 2'b00;
            m_d       = valid_in ? ctlm_in : 3'b000;
            add_d     = npc + {s_extend[29:0], 2'b00};
            alu_d     = alu_res;
            zero_d    = (alu_res == 32'd0);
            rd2_d     = rdata2;
            mux_d     = regdst ? instr_1511 : instr_2016;
            valid_d   = valid_in;
            illegal_d = valid_in & bad_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q      <= 2'b00;
            m_q       <= 3'b000;
            add_q     <= 32'd0;
            alu_q     <= 32'd0;
            zero_q    <= 1'b0;
            rd2_q     <= 32'd0;
            mux_q     <= 5'd0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            wb_q      <= wb_d;
            m_q       <= m_d;
            add_q     <= add_d;
            alu_q     <= alu_d;
            zero_q    <= zero_d;
            rd2_q     <= rd2_d;
            mux_q     <= mux_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign wb_ctlout  = wb_q;
    assign m_ctlout   = m_q;
    assign add_result = add_q;
    assign alu_result = alu_q;
    assign zero       = zero_q;
    assign rdata2out  = rd2_q;
    assign muxout     = mux_q;
    assign valid_out  = valid_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed vector table, stall/flush and reset sequences, random vs. reference model.
module tb_ex_mem;

    typedef struct packed {
        logic [1:0]  ctlwb;
        logic [2:0]  ctlm;
        logic        regdst;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [31:0] npc;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] s_extend;
        logic [4:0]  i2016;
        logic [4:0]  i1511;
        logic        valid;
    } in_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] rd2;
        logic [4:0]  mux;
        logic        valid;
        logic        illegal;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    in_t  cur = '0;
    out_t got;

    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result, alu_result, rdata2out;
    logic        zero, valid_out, illegal;
    logic [4:0]  muxout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem dut (
        .clk(clk), .rst(rst),
        .ctlwb_in(cur.ctlwb), .ctlm_in(cur.ctlm),
        .regdst(cur.regdst), .alusrc(cur.alusrc), .aluop(cur.aluop),
        .npc(cur.npc), .rdata1(cur.rdata1), .rdata2(cur.rdata2), .s_extend(cur.s_extend),
        .instr_2016(cur.i2016), .instr_1511(cur.i1511),
        .valid_in(cur.valid), .stall(stall), .flush(flush),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
        .alu_result(alu_result), .zero(zero), .rdata2out(rdata2out),
        .muxout(muxout), .valid_out(valid_out), .illegal(illegal)
    );

    always_comb got = {wb_ctlout, m_ctlout, add_result, alu_result, zero,
                       rdata2out, muxout, valid_out, illegal};

    // What the stage should present after capturing one entry, from the instruction semantics.
    function automatic out_t model(in_t i);
        out_t        o;
        logic [31:0] a, b, r;
        logic        ok;
        a  = i.rdata1;
        b  = i.alusrc ? i.s_extend : i.rdata2;
        r  = 32'd0;
        ok = 1'b1;
        if (i.aluop == 2'd0) r = a + b;
        else if (i.aluop == 2'd1) r = a - b;
        else if (i.aluop == 2'd3) ok = 1'b0;
        else if (i.s_extend[5:0] == 6'h20) r = a + b;
        else if (i.s_extend[5:0] == 6'h22) r = a - b;
        else if (i.s_extend[5:0] == 6'h24) r = a & b;
        else if (i.s_extend[5:0] == 6'h25) r = a | b;
        else if (i.s_extend[5:0] == 6'h2A) r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        else ok = 1'b0;
        o.wb      = i.valid ? i.ctlwb : 2'd0;
        o.m       = i.valid ? i.ctlm : 3'd0;
        o.add     = i.npc + i.s_extend * 4;
        o.alu     = r;
        o.zero    = (r == 0);
        o.rd2     = i.rdata2;
        o.mux     = i.regdst ? i.i1511 : i.i2016;
        o.valid   = i.valid;
        o.illegal = i.valid && !ok;
        return o;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        logic [5:0] functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        i = {$urandom, $urandom, $urandom, $urandom};
        i.valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0) i.s_extend[5:0] = functs[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) i.rdata2 = i.rdata1;
        if ($urandom_range(0, 3) == 0) i.rdata1 = 32'hFFFF_FFF0 + 32'($urandom_range(0, 31));
        return i;
    endfunction

    task automatic check(input string name, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got wb=%h m=%h add=%h alu=%h z=%b rd2=%h mux=%h v=%b ill=%b, want wb=%h m=%h add=%h alu=%h z=%b rd2=%h mux=%h v=%b ill=%b",
                     name, got.wb, got.m, got.add, got.alu, got.zero, got.rd2, got.mux, got.valid, got.illegal,
                     exp.wb, exp.m, exp.add, exp.alu, exp.zero, exp.rd2, exp.mux, exp.valid, exp.illegal);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [11];
    in_t  a_in;
    out_t exp_q;

    initial begin
        vecs[0]  = '{"rtype_add", '{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h4, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3, 1'b1},
                                  '{2'b10, 3'b000, 32'h84, 32'd12, 1'b0, 32'd7, 5'd3, 1'b1, 1'b0}};
        vecs[1]  = '{"branch_beq", '{2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'h10, 32'h10, 32'h4, 5'd5, 5'd6, 1'b1},
                                   '{2'b00, 3'b100, 32'h110, 32'd0, 1'b1, 32'h10, 5'd5, 1'b1, 1'b0}};
        vecs[2]  = '{"slt_neg_lt_pos", '{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd4, 1'b1},
                                       '{2'b10, 3'b000, 32'hA8, 32'd1, 1'b0, 32'd1, 5'd4, 1'b1, 1'b0}};
        vecs[3]  = '{"slt_pos_vs_neg", '{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd4, 1'b1},
                                       '{2'b10, 3'b000, 32'hA8, 32'd0, 1'b1, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0}};
        vecs[4]  = '{"aluop11_valid", '{2'b11, 3'b010, 1'b0, 1'b1, 2'b11, 32'h10, 32'd3, 32'd4, 32'h8, 5'd7, 5'd8, 1'b1},
                                      '{2'b11, 3'b010, 32'h30, 32'd0, 1'b1, 32'd4, 5'd7, 1'b1, 1'b1}};
        vecs[5]  = '{"aluop11_bubble", '{2'b11, 3'b010, 1'b0, 1'b1, 2'b11, 32'h10, 32'd3, 32'd4, 32'h8, 5'd7, 5'd8, 1'b0},
                                       '{2'b00, 3'b000, 32'h30, 32'd0, 1'b1, 32'd4, 5'd7, 1'b0, 1'b0}};
        vecs[6]  = '{"and_imm_opb", '{2'b01, 3'b001, 1'b0, 1'b1, 2'b10, 32'h8, 32'hFF, 32'h55, 32'h24, 5'd9, 5'd10, 1'b1},
                                    '{2'b01, 3'b001, 32'h98, 32'h24, 1'b0, 32'h55, 5'd9, 1'b1, 1'b0}};
        vecs[7]  = '{"bad_funct", '{2'b10, 3'b000, 1'b0, 1'b0, 2'b10, 32'h0, 32'd9, 32'd2, 32'h3F, 5'd0, 5'd31, 1'b1},
                                  '{2'b10, 3'b000, 32'hFC, 32'd0, 1'b1, 32'd2, 5'd0, 1'b1, 1'b1}};
        vecs[8]  = '{"add_wrap", '{2'b10, 3'b000, 1'b1, 1'b1, 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h9, 32'h1, 5'd1, 5'd17, 1'b1},
                                 '{2'b10, 3'b000, 32'h0, 32'd0, 1'b1, 32'h9, 5'd17, 1'b1, 1'b0}};
        vecs[9]  = '{"sub_wrap", '{2'b00, 3'b000, 1'b0, 1'b0, 2'b01, 32'h0, 32'd0, 32'd1, 32'h0, 5'd2, 5'd3, 1'b1},
                                 '{2'b00, 3'b000, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'd1, 5'd2, 1'b1, 1'b0}};
        vecs[10] = '{"or_funct", '{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0, 32'h0F, 32'h25, 5'd2, 5'd12, 1'b1},
                                 '{2'b10, 3'b000, 32'h94, 32'hFF, 1'b0, 32'h0F, 5'd12, 1'b1, 1'b0}};

        // Reset asserted between edges clears outputs without a clock.
        #1 rst = 1'b1;
        #2 check("reset_state", '0);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[k]) begin
            cur = vecs[k].in;
            tick();
            check(vecs[k].name, vecs[k].exp);
        end

        // Stall holds entry A across changing inputs; flush beats stall.
        a_in = vecs[0].in;
        cur = a_in;
        tick();
        check("stall_capture_a", vecs[0].exp);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cur = rand_in();
            tick();
            check("stall_hold_a", vecs[0].exp);
        end
        flush = 1'b1;
        cur = vecs[1].in;
        tick();
        check("flush_over_stall", '0);
        flush = 1'b0;
        stall = 1'b0;
        tick();
        check("resume_after_flush", vecs[1].exp);

        // Reset mid-stall discards the held entry; first free edge captures live inputs.
        cur = vecs[4].in;
        tick();
        stall = 1'b1;
        cur = vecs[6].in;
        tick();
        check("held_before_reset", vecs[4].exp);
        #2 rst = 1'b1;
        #1 check("async_reset_clear", '0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("stall_after_reset", '0);
        stall = 1'b0;
        tick();
        check("capture_after_reset", vecs[6].exp);

        // Random traffic with stall/flush against the reference model.
        exp_q = vecs[6].exp;
        for (int n = 0; n < 400; n++) begin
            cur   = rand_in();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            if (flush) exp_q = '0;
            else if (!stall) exp_q = model(cur);
            tick();
            check("random", exp_q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
